// File: rtl/mac_pkg.sv
// Shared constants and helpers for the multi-lane MAC engine.
package mac_pkg;

  localparam logic [1:0] MODE_2B = 2'd0;
  localparam logic [1:0] MODE_4B = 2'd1;
  localparam logic [1:0] MODE_8B = 2'd2;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StOut   = 2'd3;

  // Operands arrive already sign/zero-extended to 8 bits; sa/sw pick the 9th bit.
  function automatic logic signed [17:0] elem_mul(input logic [7:0] a, input logic [7:0] w,
                                                  input logic sa, input logic sw);
    logic signed [8:0]  ae;
    logic signed [8:0]  we;
    logic signed [17:0] p;
    ae = {sa & a[7], a};
    we = {sw & w[7], w};
    p  = ae * we;
    return p;
  endfunction

endpackage

// File: rtl/mac_array_engine_if.sv
// Operand and result streams of the MAC engine, both valid/ready.
interface mac_array_engine_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 24
);
  logic                   in_valid;
  logic                   in_ready;
  logic [8*LANES-1:0]     activations;
  logic [8*LANES-1:0]     weights;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W*LANES-1:0] sums;
  logic [LANES-1:0]       ovf;

  modport master (
    output in_valid, activations, weights, out_ready,
    input  in_ready, out_valid, sums, ovf
  );

  modport slave (
    input  in_valid, activations, weights, out_ready,
    output in_ready, out_valid, sums, ovf
  );
endinterface

// File: rtl/mac_lane.sv
// One MAC lane: gated operand register, packed sub-word products, saturating accumulator.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             load,
  input  logic [7:0]       a_in,
  input  logic [7:0]       w_in,
  input  logic [1:0]       mode,
  input  logic             sx,
  input  logic             sy,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic [7:0]         a_q, w_q;
  logic               vld_q;
  logic signed [17:0] ws_wide;
  logic [15:0]        word_sum;
  logic               sgn;
  logic [ACC_W:0]     acc_ext, word_ext, sum, sat_val;
  logic               sat;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;

  // Idle cycles load zero so the multipliers see no toggling.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      a_q   <= '0;
      w_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= load ? a_in : '0;
      w_q   <= load ? w_in : '0;
      vld_q <= load;
    end
  end

  always_comb begin
    logic [3:0] na, nw;
    logic [1:0] da, dw;
    ws_wide = '0;
    na = '0;
    nw = '0;
    da = '0;
    dw = '0;
    unique case (mode)
      MODE_2B: begin
        for (int k = 0; k < 4; k++) begin
          da = a_q[2*k +: 2];
          dw = w_q[2*k +: 2];
          ws_wide = ws_wide + elem_mul({{6{sx & da[1]}}, da}, {{6{sy & dw[1]}}, dw}, sx, sy);
        end
      end
      MODE_4B: begin
        for (int k = 0; k < 2; k++) begin
          na = a_q[4*k +: 4];
          nw = w_q[4*k +: 4];
          ws_wide = ws_wide + elem_mul({{4{sx & na[3]}}, na}, {{4{sy & nw[3]}}, nw}, sx, sy);
        end
      end
      default: ws_wide = elem_mul(a_q, w_q, sx, sy);
    endcase
  end

  assign word_sum = ws_wide[15:0];
  assign sgn      = sx | sy;

  // One guard bit suffices: |word_sum| < 2**16 and ACC_W >= 17.
  always_comb begin
    acc_ext  = sgn ? {acc_q[ACC_W-1], acc_q} : {1'b0, acc_q};
    word_ext = {{(ACC_W-15){sgn & word_sum[15]}}, word_sum};
    sum      = acc_ext + word_ext;
    sat      = 1'b0;
    sat_val  = sum;
    if (sgn) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        sat     = 1'b1;
        sat_val = sum[ACC_W] ? {2'b11, {(ACC_W-1){1'b0}}} : {2'b00, {(ACC_W-1){1'b1}}};
      end
    end else if (sum[ACC_W]) begin
      sat     = 1'b1;
      sat_val = {1'b0, {ACC_W{1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (vld_q) begin
      acc_q <= sat_val[ACC_W-1:0];
      ovf_q <= ovf_q | sat;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/mac_array_engine.sv
// LANES-wide MAC engine: config latch, batch FSM, beat counter and stream handshakes.
module mac_array_engine
  import mac_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned BATCH_W = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               cfg_start,
  input  logic [BATCH_W-1:0] batch_size,
  input  logic [3:0]         mode,
  input  logic               sx,
  input  logic               sy,
  mac_array_engine_if.slave  bus,
  output logic               busy,
  output logic               cfg_err
);

  logic [1:0]         state_q, state_d;
  logic [BATCH_W-1:0] cnt_q, bsize_q, last_idx;
  logic [1:0]         mode_q;
  logic               sx_q, sy_q, cfg_err_q;
  logic               cfg_go, xfer, last_beat;

  assign cfg_go    = cfg_start && (state_q == StIdle);
  assign xfer      = bus.in_valid && bus.in_ready;
  assign last_idx  = bsize_q - BATCH_W'(1);
  assign last_beat = (cnt_q == last_idx);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_start) state_d = (batch_size == '0) ? StOut : StAccum;
      StAccum: if (xfer && last_beat) state_d = StDrain;
      StDrain: state_d = StOut;
      StOut:   if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reserved modes are stored as 8bx8b so the lanes only ever see legal modes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bsize_q   <= '0;
      mode_q    <= '0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_go) begin
        cnt_q     <= '0;
        bsize_q   <= batch_size;
        mode_q    <= (mode > {2'b00, MODE_8B}) ? MODE_8B : mode[1:0];
        sx_q      <= sx;
        sy_q      <= sy;
        cfg_err_q <= (mode > {2'b00, MODE_8B});
      end else if (xfer) begin
        cnt_q <= cnt_q + BATCH_W'(1);
      end
    end
  end

  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StOut);
  assign busy          = (state_q != StIdle);
  assign cfg_err       = cfg_err_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .ACC_W (ACC_W)
    ) u_lane (
      .clk  (clk),
      .nrst (nrst),
      .clr  (cfg_go),
      .load (xfer),
      .a_in (bus.activations[8*i +: 8]),
      .w_in (bus.weights[8*i +: 8]),
      .mode (mode_q),
      .sx   (sx_q),
      .sy   (sy_q),
      .acc  (bus.sums[ACC_W*i +: ACC_W]),
      .ovf  (bus.ovf[i])
    );
  end

endmodule

// File: tb/tb_mac_array_engine.sv
// Scoreboard bench for mac_array_engine (LANES=4, ACC_W=17) with directed vectors.
module tb_mac_array_engine;

  localparam int unsigned LANES   = 4;
  localparam int unsigned ACC_W   = 17;
  localparam int unsigned BATCH_W = 8;

  typedef struct packed {
    logic [LANES*ACC_W-1:0] sums;
    logic [LANES-1:0]       ovf;
  } exp_t;

  logic               clk = 1'b0;
  logic               nrst;
  logic               cfg_start;
  logic [BATCH_W-1:0] batch_size;
  logic [3:0]         mode;
  logic               sx, sy;
  logic               busy, cfg_err;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t e;

  mac_array_engine_if #(.LANES(LANES), .ACC_W(ACC_W)) ifc ();

  mac_array_engine #(
    .LANES   (LANES),
    .ACC_W   (ACC_W),
    .BATCH_W (BATCH_W)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .cfg_start  (cfg_start),
    .batch_size (batch_size),
    .mode       (mode),
    .sx         (sx),
    .sy         (sy),
    .bus        (ifc.slave),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int s0, input int s1, input int s2, input int s3,
                              input logic [3:0] ov);
    exp_t r;
    r.sums = {s3[ACC_W-1:0], s2[ACC_W-1:0], s1[ACC_W-1:0], s0[ACC_W-1:0]};
    r.ovf  = ov;
    return r;
  endfunction

  // Monitor: a result transfers at the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (ifc.out_valid && ifc.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 128'(1), 128'(0));
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        for (int i = 0; i < LANES; i++)
          chk($sformatf("sum_lane%0d", i), 128'(ifc.sums[ACC_W*i +: ACC_W]),
              128'(x.sums[ACC_W*i +: ACC_W]));
        chk("ovf", 128'(ifc.ovf), 128'(x.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int bs, input logic [3:0] m, input logic s_x, input logic s_y);
    cfg_start  = 1'b1;
    batch_size = BATCH_W'(bs);
    mode       = m;
    sx         = s_x;
    sy         = s_y;
    tick();
    cfg_start  = 1'b0;
    batch_size = $urandom();
    mode       = $urandom();
  endtask

  task automatic send(input int n, input logic [31:0] a, input logic [31:0] w, input bit toggle);
    int got = 0;
    int cyc = 0;
    bit ph  = 1'b1;
    bit v, rdy;
    while (got < n && cyc < 200) begin
      v  = toggle ? ph : 1'b1;
      ph = ~ph;
      ifc.in_valid    = v;
      ifc.activations = v ? a : $urandom();
      ifc.weights     = v ? w : $urandom();
      rdy = ifc.in_ready;
      tick();
      if (v && rdy) got++;
      cyc++;
    end
    ifc.in_valid = 1'b0;
    if (got < n) chk("beat_timeout", 128'(got), 128'(n));
  endtask

  task automatic wait_out(input exp_t x, input int hold, input bit cfg_on_xfer);
    int k = 0;
    while (!ifc.out_valid && k < 20) begin
      tick();
      k++;
    end
    if (!ifc.out_valid) chk("out_valid_timeout", 128'(0), 128'(1));
    for (int h = 0; h < hold; h++) begin
      chk("hold_sums", 128'(ifc.sums), 128'(x.sums));
      chk("hold_valid", 128'(ifc.out_valid), 128'(1));
      tick();
    end
    ifc.out_ready = 1'b1;
    if (cfg_on_xfer) begin
      cfg_start  = 1'b1;
      batch_size = 8'd3;
    end
    tick();
    ifc.out_ready = 1'b0;
    cfg_start     = 1'b0;
    chk("valid_drop", 128'(ifc.out_valid), 128'(0));
    chk("idle_after_xfer", 128'(busy), 128'(0));
  endtask

  initial begin
    nrst            = 1'b0;
    cfg_start       = 1'b0;
    batch_size      = '0;
    mode            = '0;
    sx              = 1'b0;
    sy              = 1'b0;
    ifc.in_valid    = 1'b0;
    ifc.activations = '0;
    ifc.weights     = '0;
    ifc.out_ready   = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 128'(ifc.out_valid), 128'(0));
    chk("rst_in_ready", 128'(ifc.in_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cfg_err", 128'(cfg_err), 128'(0));
    chk("rst_sums", 128'(ifc.sums), 128'(0));
    chk("rst_ovf", 128'(ifc.ovf), 128'(0));
    nrst = 1'b1;
    tick();

    // 1: 8b unsigned, 2*3 x 3 beats
    cfg(3, 4'd2, 1'b0, 1'b0);
    chk("t1_in_ready", 128'(ifc.in_ready), 128'(1));
    e = mk(18, 18, 18, 18, 4'b0000);
    sb_q.push_back(e);
    send(3, {4{8'd2}}, {4{8'd3}}, 1'b0);
    chk("t1_drain_not_ready", 128'(ifc.in_ready), 128'(0));
    wait_out(e, 0, 1'b0);

    // 2: 4b signed; lane0 -1*1+2*3, lane1 1+1, lane2 (-1)(-1)*2, lane3 7*7+(-8)*7
    cfg(1, 4'd1, 1'b1, 1'b1);
    e = mk(5, 2, 2, -7, 4'b0000);
    sb_q.push_back(e);
    send(1, {8'h87, 8'hFF, 8'h11, 8'hF2}, {8'h77, 8'hFF, 8'h11, 8'h13}, 1'b0);
    wait_out(e, 0, 1'b0);

    // 3: 2b unsigned with toggled in_valid and held-off out_ready; cfg_start on xfer is ignored
    cfg(4, 4'd0, 1'b0, 1'b0);
    e = mk(72, 16, 0, 144, 4'b0000);
    sb_q.push_back(e);
    send(4, {8'hFF, 8'h00, 8'h55, 8'hE4}, {8'hFF, 8'hFF, 8'h55, 8'hFF}, 1'b1);
    wait_out(e, 5, 1'b1);

    // 4: saturation at 17-bit signed max; lane3 stays in range
    cfg(4, 4'd2, 1'b1, 1'b1);
    e = mk(65535, 65535, 65535, -512, 4'b0111);
    sb_q.push_back(e);
    send(4, {8'h80, 8'h80, 8'h80, 8'h80}, {8'h01, 8'h80, 8'h80, 8'h80}, 1'b0);
    wait_out(e, 0, 1'b0);

    // 5: empty batch with reserved mode goes straight to OUT and clears ovf
    cfg(0, 4'd7, 1'b0, 1'b0);
    chk("t5_out_next_edge", 128'(ifc.out_valid), 128'(1));
    chk("t5_cfg_err", 128'(cfg_err), 128'(1));
    chk("t5_ovf_cleared", 128'(ifc.ovf), 128'(0));
    e = mk(0, 0, 0, 0, 4'b0000);
    sb_q.push_back(e);
    wait_out(e, 1, 1'b0);

    // 5b: reserved mode computes 8bx8b signed
    cfg(1, 4'd7, 1'b1, 1'b1);
    chk("t5b_cfg_err", 128'(cfg_err), 128'(1));
    e = mk(-15, 16129, -16256, 1, 4'b0000);
    sb_q.push_back(e);
    send(1, {8'hFF, 8'h80, 8'h7F, 8'hFD}, {8'hFF, 8'h7F, 8'h7F, 8'h05}, 1'b0);
    wait_out(e, 0, 1'b0);
    cfg(0, 4'd2, 1'b0, 1'b0);
    chk("t5b_cfg_err_clear", 128'(cfg_err), 128'(0));
    e = mk(0, 0, 0, 0, 4'b0000);
    sb_q.push_back(e);
    wait_out(e, 0, 1'b0);

    // 6: asynchronous reset mid-batch, then a fresh batch
    cfg(5, 4'd2, 1'b0, 1'b0);
    send(2, {4{8'd1}}, {4{8'd1}}, 1'b0);
    @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    chk("t6_out_valid", 128'(ifc.out_valid), 128'(0));
    chk("t6_in_ready", 128'(ifc.in_ready), 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_sums", 128'(ifc.sums), 128'(0));
    @(negedge clk);
    nrst = 1'b1;
    tick();
    cfg(2, 4'd2, 1'b0, 1'b0);
    e = mk(200, 200, 200, 200, 4'b0000);
    sb_q.push_back(e);
    send(2, {4{8'd10}}, {4{8'd10}}, 1'b0);
    wait_out(e, 0, 1'b0);

    tick();
    tick();
    chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
